// File: rtl/pmem_arbiter.sv
// pmem_arbiter: merges two cache-line memory ports (A = instruction side,
// B = data side) onto one single-ported physical memory. One whole-line
// transaction is in flight at a time. Each granted request is latched, so
// upstream changes after the grant cannot reach the memory.
//
// state | meaning
// IDLE  | no transaction; sample requests, arbitrate, latch the winner
// BUSY  | drive the memory strobe from the latches until pmem_resp
// RESP  | one-cycle completion pulse to the winning port
module pmem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int LINE_W      = 128,
    parameter int ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [LINE_W-1:0] a_wdata,
    output logic [LINE_W-1:0] a_rdata,
    output logic              a_resp,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [LINE_W-1:0] b_wdata,
    output logic [LINE_W-1:0] b_rdata,
    output logic              b_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Port encoding used by last_grant and owner: 0 = A, 1 = B.
    logic [1:0]        state;
    logic              last_grant;
    logic              owner;
    logic              op_write;
    logic [ADDR_W-1:0] lat_address;
    logic [LINE_W-1:0] lat_wdata;

    logic req_a;
    logic req_b;
    logic grant_b;

    assign req_a = a_read | a_write;
    assign req_b = b_read | b_write;

    // Arbitration: a lone requester wins; on conflict, alternate or favour B.
    always_comb begin
        grant_b = 1'b0;
        if (req_a && req_b) begin
            grant_b = (ROUND_ROBIN != 0) ? ~last_grant : 1'b1;
        end else begin
            grant_b = req_b;
        end
    end

    // Transaction FSM with request latches and per-port read-line capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b0;
            owner       <= 1'b0;
            op_write    <= 1'b0;
            lat_address <= '0;
            lat_wdata   <= '0;
            a_rdata     <= '0;
            b_rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        owner      <= grant_b;
                        last_grant <= grant_b;
                        // A simultaneous read+write is treated as a write.
                        if (grant_b) begin
                            op_write    <= b_write;
                            lat_address <= b_address;
                            lat_wdata   <= b_wdata;
                        end else begin
                            op_write    <= a_write;
                            lat_address <= a_address;
                            lat_wdata   <= a_wdata;
                        end
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (pmem_resp) begin
                        if (!op_write) begin
                            if (owner) begin
                                b_rdata <= pmem_rdata;
                            end else begin
                                a_rdata <= pmem_rdata;
                            end
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    // Returning through IDLE gives the requester one edge to drop
                    // its request, so a completed request is never re-granted.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes and responses decode straight from state, so reset drops them at once.
    always_comb begin
        pmem_read    = (state == BUSY) && !op_write;
        pmem_write   = (state == BUSY) && op_write;
        pmem_address = lat_address;
        pmem_wdata   = lat_wdata;
        a_resp       = (state == RESP) && !owner;
        b_resp       = (state == RESP) && owner;
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: a round-robin instance with a modelled memory of
// programmable latency, plus a fixed-priority instance for grant-order checks.
module tb_pmem_arbiter;

    logic          clk;
    logic          rst;

    logic          a_read, a_write, b_read, b_write;
    logic [15:0]   a_address, b_address;
    logic [127:0]  a_wdata, b_wdata, a_rdata, b_rdata;
    logic          a_resp, b_resp;
    logic          pmem_read, pmem_write, pmem_resp;
    logic [15:0]   pmem_address;
    logic [127:0]  pmem_wdata, pmem_rdata;

    logic          f_a_read, f_a_write, f_b_read, f_b_write;
    logic [15:0]   f_a_address, f_b_address;
    logic [127:0]  f_a_wdata, f_b_wdata, f_a_rdata, f_b_rdata;
    logic          f_a_resp, f_b_resp;
    logic          f_pmem_read, f_pmem_write, f_pmem_resp;
    logic [15:0]   f_pmem_address;
    logic [127:0]  f_pmem_wdata, f_pmem_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int mem_lat = 2;
    int mem_cnt = 0;
    logic [15:0] log_addr[$];

    typedef struct {
        bit           port_b;
        bit           rd;
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        bit           exp_write;
        logic [127:0] exp_a_rdata;
        logic [127:0] exp_b_rdata;
    } vec_t;

    vec_t vecs[6];

    pmem_arbiter #(.ADDR_W(16), .LINE_W(128), .ROUND_ROBIN(1)) u_rr (
        .clk(clk), .rst(rst),
        .a_read(a_read), .a_write(a_write), .a_address(a_address), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_resp(a_resp),
        .b_read(b_read), .b_write(b_write), .b_address(b_address), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_resp(b_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    pmem_arbiter #(.ADDR_W(16), .LINE_W(128), .ROUND_ROBIN(0)) u_fp (
        .clk(clk), .rst(rst),
        .a_read(f_a_read), .a_write(f_a_write), .a_address(f_a_address), .a_wdata(f_a_wdata),
        .a_rdata(f_a_rdata), .a_resp(f_a_resp),
        .b_read(f_b_read), .b_write(f_b_write), .b_address(f_b_address), .b_wdata(f_b_wdata),
        .b_rdata(f_b_rdata), .b_resp(f_b_resp),
        .pmem_read(f_pmem_read), .pmem_write(f_pmem_write), .pmem_address(f_pmem_address),
        .pmem_wdata(f_pmem_wdata), .pmem_rdata(f_pmem_rdata), .pmem_resp(f_pmem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] mem_line(input logic [15:0] addr);
        return {32'hDEADBEEF, 80'h0, addr};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model for the round-robin instance: responds after mem_lat strobe cycles.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                mem_cnt   = 0;
            end else if (pmem_read || pmem_write) begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = mem_line(pmem_address);
                    log_addr.push_back(pmem_address);
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // Memory model for the fixed-priority instance: one-cycle latency.
    initial begin
        f_pmem_resp  = 1'b0;
        f_pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (f_pmem_resp) begin
                f_pmem_resp = 1'b0;
            end else if (f_pmem_read || f_pmem_write) begin
                f_pmem_resp  = 1'b1;
                f_pmem_rdata = mem_line(f_pmem_address);
            end
        end
    end

    // Mutual-exclusion watch on strobes and responses of both instances.
    initial begin
        forever begin
            @(negedge clk);
            if (pmem_read || pmem_write || a_resp || b_resp) begin
                chk("no_strobe_overlap", {1'b0, pmem_read & pmem_write}, 2'b00);
                chk("no_resp_overlap", {1'b0, a_resp & b_resp}, 2'b00);
            end
            if (f_pmem_read || f_pmem_write || f_a_resp || f_b_resp) begin
                chk("f_no_strobe_overlap", {1'b0, f_pmem_read & f_pmem_write}, 2'b00);
                chk("f_no_resp_overlap", {1'b0, f_a_resp & f_b_resp}, 2'b00);
            end
        end
    end

    task automatic wait_resp(input string name, output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_resp || b_resp) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no resp within 40 cycles", name);
        end
    endtask

    task automatic wait_f_resp(input string name, output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (f_a_resp || f_b_resp) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no resp within 40 cycles", name);
        end
    endtask

    task automatic clear_inputs();
        a_read = 0; a_write = 0; a_address = '0; a_wdata = '0;
        b_read = 0; b_write = 0; b_address = '0; b_wdata = '0;
        f_a_read = 0; f_a_write = 0; f_a_address = '0; f_a_wdata = '0;
        f_b_read = 0; f_b_write = 0; f_b_address = '0; f_b_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit found;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        if (v.port_b) begin
            b_read = v.rd; b_write = v.wr; b_address = v.addr; b_wdata = v.wdata;
        end else begin
            a_read = v.rd; a_write = v.wr; a_address = v.addr; a_wdata = v.wdata;
        end
        @(negedge clk);
        chk({tag, "_pmem_write"}, pmem_write, v.exp_write);
        chk({tag, "_pmem_read"}, pmem_read, !v.exp_write);
        chk({tag, "_pmem_address"}, pmem_address, v.addr);
        if (v.exp_write) chk({tag, "_pmem_wdata"}, pmem_wdata, v.wdata);
        wait_resp(tag, found);
        if (found) begin
            chk({tag, "_a_resp"}, a_resp, !v.port_b);
            chk({tag, "_b_resp"}, b_resp, v.port_b);
            chk({tag, "_a_rdata"}, a_rdata, v.exp_a_rdata);
            chk({tag, "_b_rdata"}, b_rdata, v.exp_b_rdata);
        end
        a_read = 0; a_write = 0; b_read = 0; b_write = 0;
        @(negedge clk);
        chk({tag, "_resp_single"}, {a_resp, b_resp}, 2'b00);
        chk({tag, "_idle_strobes"}, {pmem_read, pmem_write}, 2'b00);
    endtask

    initial begin
        bit found;
        bit exp_ord[4];
        logic [127:0] wa;
        wa = 128'hCAFEF00D_11112222_33334444_55556666;

        vecs[0] = '{0, 1, 0, 16'h0040, 128'h0, 0,
                    128'hDEADBEEF_00000000_00000000_00000040, 128'h0};
        vecs[1] = '{1, 0, 1, 16'h1230, 128'h0123456789ABCDEF_0123456789ABCDEF, 1,
                    128'hDEADBEEF_00000000_00000000_00000040, 128'h0};
        vecs[2] = '{0, 1, 1, 16'h0777, 128'h55555555_55555555_55555555_55555555, 1,
                    128'hDEADBEEF_00000000_00000000_00000040, 128'h0};
        vecs[3] = '{1, 1, 0, 16'h0F0F, 128'h0, 0,
                    128'hDEADBEEF_00000000_00000000_00000040,
                    128'hDEADBEEF_00000000_00000000_00000F0F};
        vecs[4] = '{0, 0, 1, 16'h0001, 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000, 1,
                    128'hDEADBEEF_00000000_00000000_00000040,
                    128'hDEADBEEF_00000000_00000000_00000F0F};
        vecs[5] = '{0, 1, 0, 16'h0ABC, 128'h0, 0,
                    128'hDEADBEEF_00000000_00000000_00000ABC,
                    128'hDEADBEEF_00000000_00000000_00000F0F};

        clear_inputs();
        rst = 1'b1;
        #1;
        chk("reset_strobes", {pmem_read, pmem_write}, 2'b00);
        chk("reset_resps", {a_resp, b_resp}, 2'b00);
        chk("reset_address", pmem_address, 16'h0000);
        chk("reset_wdata", pmem_wdata, 128'h0);
        chk("reset_a_rdata", a_rdata, 128'h0);
        chk("reset_b_rdata", b_rdata, 128'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single-port transactions from the vector table.
        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Simultaneous requests right after reset: B wins first, then A.
        do_reset();
        log_addr.delete();
        a_read = 1; a_address = 16'h0100;
        b_read = 1; b_address = 16'h0200;
        wait_resp("conflict_first", found);
        if (found) begin
            chk("conflict_first_b_resp", b_resp, 1'b1);
            chk("conflict_first_a_resp", a_resp, 1'b0);
            chk("conflict_first_b_rdata", b_rdata, 128'hDEADBEEF_00000000_00000000_00000200);
        end
        b_read = 0;
        wait_resp("conflict_second", found);
        if (found) begin
            chk("conflict_second_a_resp", a_resp, 1'b1);
            chk("conflict_second_a_rdata", a_rdata, 128'hDEADBEEF_00000000_00000000_00000100);
        end
        a_read = 0;
        chk("conflict_log_size", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            chk("conflict_log0", log_addr[0], 16'h0200);
            chk("conflict_log1", log_addr[1], 16'h0100);
        end

        // Continuous requests from both ports: round-robin alternates B,A,B,A.
        do_reset();
        exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
        a_read = 1; a_address = 16'h0A00;
        b_read = 1; b_address = 16'h0B00;
        for (int i = 0; i < 4; i++) begin
            wait_resp($sformatf("rr_grant%0d", i), found);
            if (found) chk($sformatf("rr_grant%0d_is_b", i), b_resp, exp_ord[i]);
        end
        a_read = 0; b_read = 0;

        // Same pattern on the fixed-priority instance: B every time, A starves.
        f_a_read = 1; f_a_address = 16'h0A00;
        f_b_read = 1; f_b_address = 16'h0B00;
        for (int i = 0; i < 4; i++) begin
            wait_f_resp($sformatf("fp_grant%0d", i), found);
            if (found) begin
                chk($sformatf("fp_grant%0d_b", i), f_b_resp, 1'b1);
                chk($sformatf("fp_grant%0d_a", i), f_a_resp, 1'b0);
            end
        end
        f_b_read = 0;
        wait_f_resp("fp_a_after_b", found);
        if (found) begin
            chk("fp_a_after_b_resp", f_a_resp, 1'b1);
            chk("fp_a_after_b_rdata", f_a_rdata, 128'hDEADBEEF_00000000_00000000_00000A00);
        end
        f_a_read = 0;
        repeat (2) @(negedge clk);

        // Upstream address/data changes during BUSY must not reach memory.
        mem_lat = 4;
        @(negedge clk);
        a_write = 1; a_address = 16'h0300; a_wdata = wa;
        @(negedge clk);
        a_address = 16'hFFFF; a_wdata = ~wa;
        @(negedge clk);
        chk("latch_write", pmem_write, 1'b1);
        chk("latch_address", pmem_address, 16'h0300);
        chk("latch_wdata", pmem_wdata, wa);
        wait_resp("latch_resp", found);
        if (found) chk("latch_a_resp", a_resp, 1'b1);
        a_write = 0;
        chk("latch_log_last", log_addr[$], 16'h0300);

        // Reset in the middle of BUSY, then the held request completes normally.
        mem_lat = 50;
        @(negedge clk);
        a_read = 1; a_address = 16'h0444;
        @(negedge clk);
        chk("midrst_busy_read", pmem_read, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_strobes", {pmem_read, pmem_write}, 2'b00);
        chk("midrst_resps", {a_resp, b_resp}, 2'b00);
        chk("midrst_a_rdata", a_rdata, 128'h0);
        @(negedge clk);
        chk("midrst_hold_resps", {a_resp, b_resp}, 2'b00);
        mem_lat = 2;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_regrant_read", pmem_read, 1'b1);
        chk("midrst_regrant_addr", pmem_address, 16'h0444);
        wait_resp("midrst_resp", found);
        if (found) begin
            chk("midrst_a_resp", a_resp, 1'b1);
            chk("midrst_a_rdata_new", a_rdata, 128'hDEADBEEF_00000000_00000000_00000444);
        end
        a_read = 0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
